// File: rtl/tx_upconverter_if.sv
// Baseband-in / RF-out bundle for tx_upconverter.
//
// Signals:
//   bb_i, bb_q   5-bit signed baseband sample        (master -> slave)
//   bb_valid     upstream has a sample on bb_i/bb_q   (master -> slave)
//   bb_ready     block takes a sample this cycle      (slave -> master)
//   freq_word    NCO phase increment per clk_en       (master -> slave)
//   rf_i, rf_q   10-bit signed upconverted output     (slave -> master)
//   rf_valid     one-clock pulse when rf_i/rf_q update (slave -> master)
//   underrun     sticky: a sample slot passed without a valid sample
//
// The slave modport is the upconverter; the master is the upstream/downstream side.
interface tx_upconverter_if #(
    parameter int unsigned PHASE_W = 16
);
    logic signed [4:0]  bb_i;
    logic signed [4:0]  bb_q;
    logic               bb_valid;
    logic               bb_ready;
    logic [PHASE_W-1:0] freq_word;
    logic signed [9:0]  rf_i;
    logic signed [9:0]  rf_q;
    logic               rf_valid;
    logic               underrun;

    modport master (
        output bb_i, bb_q, bb_valid, freq_word,
        input  bb_ready, rf_i, rf_q, rf_valid, underrun
    );

    modport slave (
        input  bb_i, bb_q, bb_valid, freq_word,
        output bb_ready, rf_i, rf_q, rf_valid, underrun
    );
endinterface

// File: rtl/tx_upconverter.sv
// Transmit complex upconverter: zero-order-holds 5-bit signed baseband I/Q for INTERP
// enabled cycles and multiplies it by an NCO local oscillator e^{+jwt} built from a
// phase accumulator and a 32-entry cosine table, giving 10-bit signed rf_i/rf_q.
//
// Ports:
//   clock    system clock, all state on its rising edge
//   reset    synchronous, active-high; overrides clk_en
//   clk_en   sample-rate enable; state advances only when high
//   up_if    tx_upconverter_if.slave: baseband handshake, freq_word, rf outputs, underrun
//
// Build option:
//   TX_UPCONV_UNDERRUN_HOLD_EN  defined: an underrun slot repeats the last sample;
//                               undefined: an underrun slot loads zero (silence).
module tx_upconverter #(
    parameter int unsigned INTERP  = 4,
    parameter int unsigned PHASE_W = 16
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           clk_en,
    tx_upconverter_if.slave up_if
);

    localparam int unsigned CntW = (INTERP > 1) ? $clog2(INTERP) : 1;

    // round(15 * cos(2*pi*n/32))
    localparam logic signed [4:0] CosLut [32] = '{
        5'sd15,  5'sd15,  5'sd14,  5'sd12,  5'sd11,  5'sd8,   5'sd6,   5'sd3,
        5'sd0,  -5'sd3,  -5'sd6,  -5'sd8,  -5'sd11, -5'sd12, -5'sd14, -5'sd15,
        -5'sd15, -5'sd15, -5'sd14, -5'sd12, -5'sd11, -5'sd8,  -5'sd6,  -5'sd3,
        5'sd0,   5'sd3,   5'sd6,   5'sd8,   5'sd11,  5'sd12,  5'sd14,  5'sd15
    };

    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [PHASE_W-1:0] phase_q, phase_d;
    logic [PHASE_W-1:0] freq_q, freq_d;
    logic signed [4:0]  hold_i_q, hold_i_d, hold_q_q, hold_q_d;
    logic signed [4:0]  dly_i_q, dly_i_d, dly_q_q, dly_q_d;
    logic signed [4:0]  lo_i_q, lo_i_d, lo_q_q, lo_q_d;
    logic signed [9:0]  rf_i_q, rf_i_d, rf_q_q, rf_q_d;
    logic               rf_valid_q, rf_valid_d;
    logic               underrun_q, underrun_d;
    logic [1:0]         fill_q, fill_d;

    logic               bb_ready;
    logic [4:0]         idx;
    logic signed [9:0]  di, dq, li, lq;

    assign bb_ready = clk_en & (cnt_q == '0) & ~reset;
    assign idx      = phase_q[PHASE_W-1 -: 5];

    // Widen before multiplying: |product| <= 256 and |sum| <= 480, so 10-bit
    // wrap-around arithmetic yields the exact result.
    assign di = 10'(dly_i_q);
    assign dq = 10'(dly_q_q);
    assign li = 10'(lo_i_q);
    assign lq = 10'(lo_q_q);

    always_comb begin
        cnt_d      = cnt_q;
        phase_d    = phase_q;
        freq_d     = freq_q;
        hold_i_d   = hold_i_q;
        hold_q_d   = hold_q_q;
        dly_i_d    = dly_i_q;
        dly_q_d    = dly_q_q;
        lo_i_d     = lo_i_q;
        lo_q_d     = lo_q_q;
        rf_i_d     = rf_i_q;
        rf_q_d     = rf_q_q;
        rf_valid_d = 1'b0;
        underrun_d = underrun_q;
        fill_d     = fill_q;

        if (clk_en) begin
            cnt_d   = (cnt_q == CntW'(INTERP - 1)) ? '0 : cnt_q + CntW'(1);
            // Uses the pre-transfer freq_q, so a new word applies from the next increment.
            phase_d = phase_q + freq_q;
            lo_i_d  = CosLut[idx];
            lo_q_d  = CosLut[idx - 5'd8];
            dly_i_d = hold_i_q;
            dly_q_d = hold_q_q;
            rf_i_d  = di * li - dq * lq;
            rf_q_d  = di * lq + dq * li;

            // Two enabled edges must pass before rf carries an accepted sample.
            rf_valid_d = (fill_q == 2'd2);
            if (fill_q != 2'd2) begin
                fill_d = fill_q + 2'd1;
            end

            if (bb_ready) begin
                if (up_if.bb_valid) begin
                    hold_i_d = up_if.bb_i;
                    hold_q_d = up_if.bb_q;
                    freq_d   = up_if.freq_word;
                end else begin
                    underrun_d = 1'b1;
`ifdef TX_UPCONV_UNDERRUN_HOLD_EN
                    hold_i_d = hold_i_q;
                    hold_q_d = hold_q_q;
`else
                    hold_i_d = '0;
                    hold_q_d = '0;
`endif
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q      <= '0;
            phase_q    <= '0;
            freq_q     <= '0;
            hold_i_q   <= '0;
            hold_q_q   <= '0;
            dly_i_q    <= '0;
            dly_q_q    <= '0;
            lo_i_q     <= '0;
            lo_q_q     <= '0;
            rf_i_q     <= '0;
            rf_q_q     <= '0;
            rf_valid_q <= 1'b0;
            underrun_q <= 1'b0;
            fill_q     <= '0;
        end else begin
            cnt_q      <= cnt_d;
            phase_q    <= phase_d;
            freq_q     <= freq_d;
            hold_i_q   <= hold_i_d;
            hold_q_q   <= hold_q_d;
            dly_i_q    <= dly_i_d;
            dly_q_q    <= dly_q_d;
            lo_i_q     <= lo_i_d;
            lo_q_q     <= lo_q_d;
            rf_i_q     <= rf_i_d;
            rf_q_q     <= rf_q_d;
            rf_valid_q <= rf_valid_d;
            underrun_q <= underrun_d;
            fill_q     <= fill_d;
        end
    end

    assign up_if.bb_ready = bb_ready;
    assign up_if.rf_i     = rf_i_q;
    assign up_if.rf_q     = rf_q_q;
    assign up_if.rf_valid = rf_valid_q;
    assign up_if.underrun = underrun_q;

endmodule

// File: doc/tx_upconverter.md
Name: tx_upconverter

Overview:
- Transmit-side complement of the receive complex mixer: accepts 5-bit signed baseband I/Q at a reduced rate through a valid/ready handshake.
- Zero-order-holds each baseband sample for INTERP clock-enabled cycles.
- Generates an internal NCO local oscillator (phase accumulator plus 32-entry cosine table).
- Outputs the complex product bb × e^{+jωt} as 10-bit signed rf_i/rf_q, which feeds the DAC path.

Parameters:
- INTERP, 4, clock-enabled cycles per baseband sample; legal range 1..256.
- PHASE_W, 16, phase accumulator width in bits; minimum 5.

Ports:
- clock  input  1  system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- clk_en  input  1  sample-rate enable; all state advances only when high.
- bb_i  input  5  signed baseband I.
- bb_q  input  5  signed baseband Q.
- bb_valid  input  1  upstream has a sample on bb_i/bb_q.
- bb_ready  output  1  block takes a sample this cycle.
- freq_word  input  PHASE_W  unsigned NCO phase increment per clk_en.
- rf_i  output  10  signed upconverted I.
- rf_q  output  10  signed upconverted Q.
- rf_valid  output  1  one-clock pulse when rf_i/rf_q update.
- underrun  output  1  sticky flag: a slot passed with no valid sample.

Behaviour:
- Reset (synchronous, active-high): clears phase, interp_cnt, hold_i/q, freq_reg, lo_i/q, bb_d_i/q, rf_i, rf_q, rf_valid and underrun to 0. Reset has priority over clk_en. Reset mid-operation discards any in-flight pipeline data.
- Interpolation counter:
  - interp_cnt counts 0..INTERP-1 on each clk_en and wraps to 0.
  - INTERP=1 means every clk_en is a sample slot.
- Ready:
  - bb_ready = clk_en & (interp_cnt==0) & ~reset, combinational.
  - bb_ready is 0 whenever clk_en is low.
  - bb_ready never depends on bb_valid.
- Transfer: when bb_valid & bb_ready:
  - hold_i/q <= bb_i/q.
  - freq_reg <= freq_word. The frequency changes only at sample boundaries.
  - freq_word is ignored at all other times.
- Underrun:
  - Triggered when bb_ready is high and bb_valid is low.
  - Sets underrun; it stays set until reset.
  - hold_i/q is loaded per the Optional Feature.
  - freq_reg is unchanged.
- NCO:
  - On each clk_en, phase <= phase + freq_reg, modulo 2^PHASE_W.
  - idx = phase[PHASE_W-1:PHASE_W-5].
- LO table:
  - COS[n] = round(15·cos(2πn/32)) for n = 0..31, range ±15.
  - lo_i <= COS[idx].
  - lo_q <= COS[(idx-8) mod 32], i.e. the sine.
  - Both are registered on clk_en and computed from the pre-update phase.
- Pipeline, counted in clk_en edges:
  - Edge k: hold loads (transfer).
  - Edge k+1: bb_d <= hold; lo registered.
  - Edge k+2: rf outputs update:
    - rf_i <= bb_d_i·lo_i − bb_d_q·lo_q
    - rf_q <= bb_d_i·lo_q + bb_d_q·lo_i
  - All multiplies and sums are signed.
  - Latency: 2 clk_en edges from acceptance to the first rf output carrying that sample.
- Widths: worst case |16·15 + 16·15| = 480 fits the 10-bit signed range, so no saturation logic is needed. The exact 10-bit result is required.
- rf_valid: high for exactly the clock cycle following each clk_en edge once the pipeline has filled. It is low for the first 2 clk_en edges after reset.
- clk_en low: all registers hold; rf_valid is 0.
- Simultaneous events: freq_word changes coincident with a transfer take effect from the next phase increment. bb_valid with bb_ready low is ignored; upstream must hold the sample.

Optional Feature:
- Macro: TX_UPCONV_UNDERRUN_HOLD_EN.
- Defined: on underrun, hold_i/q retains the previous sample (last-value hold).
- Undefined: on underrun, hold_i/q loads 0, producing silence.
- The underrun flag behaves identically in both builds.

Test Plan:
- DC LO: reset, freq_word=0, INTERP=4, clk_en=1, bb=(3,−2) held valid:
  - bb_ready pulses every 4 clocks.
  - After 2 edges, rf_i=45, rf_q=−30 and hold constant; rf_valid high each cycle.
- Quarter-rate LO: freq_word=2^(PHASE_W−2), bb=(1,0):
  - rf_i sequence 15, 0, −15, 0.
  - rf_q sequence 0, 15, 0, −15, repeating.
- Extremes: freq_word=0, bb=(−16,−16) → rf_i=−240, rf_q=−240. With LO at idx 4 (phase=2^(PHASE_W−3), freq_word=0; COS[4]=11, COS[−4 mod 32]=11) → rf_i=0, rf_q=−352.
- Underrun: bb_valid low in one slot:
  - underrun=1 and stays 1.
  - rf output for that slot: 0 (macro undefined) or the previous product (macro defined).
- clk_en gating: clk_en toggles 1-of-3 cycles → outputs, phase and handshake advance only on enabled cycles; rf_valid never high two clocks in a row.
- Mid-run reset: assert reset for 1 clock during streaming → next cycle all outputs 0, underrun=0, phase=0; first rf_valid occurs 2 clk_en edges after the first post-reset transfer.
